// File: rtl/or_engine_pkg.sv
// Shared definitions for the OR engine command driver: register map,
// driver state encoding and default widths.
package or_engine_pkg;

    localparam int DATA_W_DEFAULT = 8;
    localparam int ADDR_W_DEFAULT = 3;

    // Engine register map
    localparam int ADDR_A_STATUS = 0;  // bit0: operand A FIFO has space
    localparam int ADDR_B_STATUS = 1;  // bit0: operand B FIFO has space
    localparam int ADDR_Y_STATUS = 2;  // bit0: result FIFO not empty
    localparam int ADDR_Y_DATA   = 3;  // result head, read_en dequeues
    localparam int ADDR_A_DATA   = 4;  // operand A push
    localparam int ADDR_B_DATA   = 5;  // operand B push

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POLL_A = 3'd1,
        WR_A   = 3'd2,
        POLL_B = 3'd3,
        WR_B   = 3'd4,
        POLL_Y = 3'd5,
        RD_Y   = 3'd6,
        RSP    = 3'd7
    } drv_state_e;

    // True for the three status-polling states that share the timeout counter.
    function automatic logic is_poll(drv_state_e s);
        return (s == POLL_A) || (s == POLL_B) || (s == POLL_Y);
    endfunction

endpackage

// File: rtl/or_drv_poll_timer.sv
// Clearable poll counter. 'last' flags the TIMEOUT-th consecutive failing
// poll cycle so the FSM can abort in that same cycle.
module or_drv_poll_timer #(
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 10
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clr,
    input  logic inc,
    output logic last
);

    logic [TO_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/or_engine_driver.sv
// Upstream command driver for the register-mapped OR engine. Takes one
// operand pair, runs poll/write/poll/write/poll/read against the engine and
// returns the result (or a poll-timeout error) on the response stream.
// Handshakes: a transfer happens on a rising CLK edge where valid && ready;
// valid-side data holds stable until that edge.
// Optional feature macro: OR_DRV_LAT_EN adds rsp_lat (accept-to-RD_Y cycles).
module or_engine_driver
    import or_engine_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int ADDR_W  = ADDR_W_DEFAULT,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 10
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] write_data,
    output logic              write_en,
    input  logic              write_rdy,
    output logic [ADDR_W-1:0] read_address,
    output logic              read_en,
    input  logic [DATA_W-1:0] read_data,
    input  logic              read_rdy,
    output logic [2:0]        dbg_state
`ifdef OR_DRV_LAT_EN
    ,
    output logic [TO_W+1:0]   rsp_lat
`endif
);

    drv_state_e        state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] write_address_q, write_address_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic              write_en_q, write_en_d;
    logic [ADDR_W-1:0] read_address_q, read_address_d;
    logic              read_en_q, read_en_d;

    logic poll_ok, poll_last, poll_clr, poll_inc;

    // Status bit is only trusted while the read port reports ready.
    assign poll_ok  = read_rdy && read_data[0];
    assign poll_clr = !is_poll(state_q);
    assign poll_inc = is_poll(state_q) && !poll_ok && !poll_last;

    or_drv_poll_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_poll_timer (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (poll_clr),
        .inc   (poll_inc),
        .last  (poll_last)
    );

    // Next state, operand/response capture, and bus outputs decoded from the
    // next state so every output is a flop.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    state_d = POLL_A;
                end
            end
            POLL_A, POLL_B, POLL_Y: begin
                if (poll_ok) begin
                    state_d = (state_q == POLL_A) ? WR_A :
                              (state_q == POLL_B) ? WR_B : RD_Y;
                end else if (poll_last) begin
                    state_d    = RSP;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                end
            end
            WR_A: if (write_rdy) state_d = POLL_B;
            WR_B: if (write_rdy) state_d = POLL_Y;
            RD_Y: begin
                if (read_rdy) begin
                    rsp_data_d = read_data;
                    rsp_err_d  = 1'b0;
                    state_d    = RSP;
                end
            end
            RSP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        cmd_ready_d     = (state_d == IDLE);
        rsp_valid_d     = (state_d == RSP);
        busy_d          = (state_d != IDLE);
        write_en_d      = (state_d == WR_A) || (state_d == WR_B);
        write_address_d = (state_d == WR_A) ? ADDR_W'(ADDR_A_DATA) :
                          (state_d == WR_B) ? ADDR_W'(ADDR_B_DATA) : '0;
        write_data_d    = (state_d == WR_A) ? a_d :
                          (state_d == WR_B) ? b_d : '0;
        read_en_d       = (state_d == RD_Y);
        case (state_d)
            POLL_B:  read_address_d = ADDR_W'(ADDR_B_STATUS);
            POLL_Y:  read_address_d = ADDR_W'(ADDR_Y_STATUS);
            RD_Y:    read_address_d = ADDR_W'(ADDR_Y_DATA);
            default: read_address_d = ADDR_W'(ADDR_A_STATUS);
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q         <= IDLE;
            a_q             <= '0;
            b_q             <= '0;
            rsp_data_q      <= '0;
            rsp_err_q       <= 1'b0;
            cmd_ready_q     <= 1'b1;
            rsp_valid_q     <= 1'b0;
            busy_q          <= 1'b0;
            write_address_q <= '0;
            write_data_q    <= '0;
            write_en_q      <= 1'b0;
            read_address_q  <= '0;
            read_en_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            a_q             <= a_d;
            b_q             <= b_d;
            rsp_data_q      <= rsp_data_d;
            rsp_err_q       <= rsp_err_d;
            cmd_ready_q     <= cmd_ready_d;
            rsp_valid_q     <= rsp_valid_d;
            busy_q          <= busy_d;
            write_address_q <= write_address_d;
            write_data_q    <= write_data_d;
            write_en_q      <= write_en_d;
            read_address_q  <= read_address_d;
            read_en_q       <= read_en_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_err       = rsp_err_q;
    assign busy          = busy_q;
    assign write_address = write_address_q;
    assign write_data    = write_data_q;
    assign write_en      = write_en_q;
    assign read_address  = read_address_q;
    assign read_en       = read_en_q;
    assign dbg_state     = state_q;

`ifdef OR_DRV_LAT_EN
    logic [TO_W+1:0] lat_q, lat_d;

    // Latency: cleared on accept, counts every cycle before RD_Y, saturates.
    always_comb begin
        lat_d = lat_q;
        if (state_q == IDLE) begin
            if (cmd_valid) lat_d = '0;
        end else if ((state_q != RD_Y) && (state_q != RSP) && (lat_q != '1)) begin
            lat_d = lat_q + 1'b1;
        end
    end

    // Latency register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lat_q <= '0;
        end else begin
            lat_q <= lat_d;
        end
    end

    assign rsp_lat = lat_q;
`endif

endmodule

// File: tb/tb_or_engine_driver.sv
// Bench for or_engine_driver: behavioural single-entry OR engine, table
// vectors, hand sequences for stalls/backpressure/timeout/reset, and a
// randomized run checked against a scoreboard of A|B.
module tb_or_engine_driver;

    localparam int DW  = 8;
    localparam int AW  = 3;
    localparam int TMO = 16;
    localparam int TW  = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready;
    logic [DW-1:0] cmd_a, cmd_b;
    logic          rsp_valid, rsp_ready, rsp_err, busy;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] write_address, read_address;
    logic [DW-1:0] write_data, read_data;
    logic          write_en, write_rdy, read_en, read_rdy;
    logic [2:0]    dbg_state;
`ifdef OR_DRV_LAT_EN
    logic [TW+1:0] rsp_lat;
`endif

    always #5 clk = ~clk;

    or_engine_driver #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .TIMEOUT (TMO),
        .TO_W    (TW)
    ) dut (
        .CLK           (clk),
        .RST_N         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_a         (cmd_a),
        .cmd_b         (cmd_b),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .busy          (busy),
        .write_address (write_address),
        .write_data    (write_data),
        .write_en      (write_en),
        .write_rdy     (write_rdy),
        .read_address  (read_address),
        .read_en       (read_en),
        .read_data     (read_data),
        .read_rdy      (read_rdy),
        .dbg_state     (dbg_state)
`ifdef OR_DRV_LAT_EN
        ,
        .rsp_lat       (rsp_lat)
`endif
    );

    // ---------------- engine model ----------------
    logic          a_full, b_full, y_full;
    logic [DW-1:0] a_val, b_val, y_val;
    logic          na_full, nb_full, ny_full, n_ovf;
    logic [DW-1:0] na_val, nb_val, ny_val;
    logic          y_block = 1'b0, stall_en = 1'b0, eng_stall;
    int            stall_run;
    logic          wr_hold = 1'b0, rd_hold = 1'b0, rand_rdy = 1'b0, wr_rand = 1'b1;

    assign write_rdy = wr_hold ? 1'b0 : (rand_rdy ? wr_rand : 1'b1);
    assign read_rdy  = !rd_hold;

    always @(negedge clk) wr_rand <= ($urandom_range(0, 3) != 0);

    always_comb begin
        na_full = a_full; na_val = a_val;
        nb_full = b_full; nb_val = b_val;
        ny_full = y_full; ny_val = y_val;
        n_ovf   = 1'b0;
        if (write_en && write_rdy) begin
            if (write_address == 3'd4) begin
                n_ovf = a_full; na_full = 1'b1; na_val = write_data;
            end else if (write_address == 3'd5) begin
                n_ovf = b_full; nb_full = 1'b1; nb_val = write_data;
            end
        end
        if (read_en && read_rdy && read_address == 3'd3) ny_full = 1'b0;
        if (na_full && nb_full && !ny_full && !y_block) begin
            ny_full = 1'b1; ny_val = na_val | nb_val;
            na_full = 1'b0; nb_full = 1'b0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_full <= 1'b0; b_full <= 1'b0; y_full <= 1'b0;
            a_val <= '0; b_val <= '0; y_val <= '0;
            eng_stall <= 1'b0; stall_run <= 0;
        end else begin
            a_full <= na_full; a_val <= na_val;
            b_full <= nb_full; b_val <= nb_val;
            y_full <= ny_full; y_val <= ny_val;
            if (stall_en && stall_run < 3 && $urandom_range(0, 2) == 0) begin
                eng_stall <= 1'b1; stall_run <= stall_run + 1;
            end else begin
                eng_stall <= 1'b0; stall_run <= 0;
            end
        end
    end

    always_comb begin
        read_data = '0;
        case (read_address)
            3'd0: read_data[0] = !a_full && !eng_stall;
            3'd1: read_data[0] = !b_full && !eng_stall;
            3'd2: read_data[0] = y_full && !eng_stall;
            3'd3: read_data = y_val;
            default: read_data = '0;
        endcase
    end

    // ---------------- bus monitor ----------------
    int            wa_cnt = 0, wb_cnt = 0, ry_cnt = 0, viol = 0, ovf = 0;
    logic [DW-1:0] wa_last = '0, wb_last = '0;

    always @(posedge clk) begin
        if (write_en && write_rdy && write_address == 3'd4) begin
            wa_cnt <= wa_cnt + 1; wa_last <= write_data;
        end
        if (write_en && write_rdy && write_address == 3'd5) begin
            wb_cnt <= wb_cnt + 1; wb_last <= write_data;
        end
        if (read_en && read_rdy && read_address == 3'd3) ry_cnt <= ry_cnt + 1;
        if (read_en && read_address != 3'd3) viol <= viol + 1;
        if (n_ovf) ovf <= ovf + 1;
    end

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_write_en"}, write_en, 0);
        chk({tag, "_read_en"}, read_en, 0);
        chk({tag, "_write_address"}, write_address, 0);
        chk({tag, "_read_address"}, read_address, 0);
        chk({tag, "_write_data"}, write_data, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Presents one pair; returns at the negedge following the accept edge.
    task automatic send_cmd(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int guard = 0;
        while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
        chk("cmd_ready_before_send", cmd_ready, 1);
        cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Counts edges from the accept edge until rsp_valid is seen.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 1000) begin @(negedge clk); lat++; end
        chk("rsp_valid_within_budget", rsp_valid, 1);
    endtask

    task automatic take_rsp(output logic [DW-1:0] d, output logic e);
        d = rsp_data; e = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t vecs[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            lat, bad, guard, py, w0, w1, r0;
        logic [DW-1:0] d, a, b;
        logic          e;

        vecs[0] = '{8'h0F, 8'hF0, 8'hFF};
        vecs[1] = '{8'h81, 8'h18, 8'h99};
        vecs[2] = '{8'h00, 8'h00, 8'h00};
        vecs[3] = '{8'hFF, 8'h00, 8'hFF};
        vecs[4] = '{8'hAA, 8'h55, 8'hFF};
        vecs[5] = '{8'h01, 8'h02, 8'h03};
        vecs[6] = '{8'h12, 8'h34, 8'h36};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic transaction with bus accounting and minimum latency.
        w0 = wa_cnt; w1 = wb_cnt; r0 = ry_cnt;
        send_cmd(8'h0F, 8'hF0);
        wait_rsp(lat);
        chk("basic_latency", lat, 7);
        take_rsp(d, e);
        chk("basic_data", d, 8'hFF);
        chk("basic_err", e, 0);
        chk("basic_writes_a", wa_cnt - w0, 1);
        chk("basic_write_a_data", wa_last, 8'h0F);
        chk("basic_writes_b", wb_cnt - w1, 1);
        chk("basic_write_b_data", wb_last, 8'hF0);
        chk("basic_reads_y", ry_cnt - r0, 1);

        // Table vectors.
        foreach (vecs[i]) begin
            send_cmd(vecs[i].a, vecs[i].b);
            wait_rsp(lat);
            chk($sformatf("vec%0d_latency", i), lat, 7);
            take_rsp(d, e);
            chk($sformatf("vec%0d_data", i), d, vecs[i].exp);
            chk($sformatf("vec%0d_err", i), e, 0);
        end

        // Response backpressure.
        send_cmd(8'h81, 8'h18);
        wait_rsp(lat);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid !== 1'b1 || rsp_data !== 8'h99 || cmd_ready !== 1'b0 || rsp_err !== 1'b0)
                bad++;
            @(negedge clk);
        end
        chk("bp_hold_unstable_cycles", bad, 0);
        take_rsp(d, e);
        chk("bp_data", d, 8'h99);
        chk("bp_idle_after_handshake_busy", busy, 0);
        chk("bp_idle_after_handshake_cmd_ready", cmd_ready, 1);

        // Port stalls: write port held off in WR_A, read port held off in RD_Y.
        w0 = wa_cnt; w1 = wb_cnt; r0 = ry_cnt;
        wr_hold = 1'b1;
        send_cmd(8'h3C, 8'h41);
        guard = 0;
        while (!write_en && guard < 50) begin @(negedge clk); guard++; end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (write_en !== 1'b1 || write_address !== 3'd4 || write_data !== 8'h3C) bad++;
            @(negedge clk);
        end
        chk("stall_write_held_bad_cycles", bad, 0);
        chk("stall_write_none_completed", wa_cnt - w0, 0);
        wr_hold = 1'b0;
        guard = 0;
        while (!read_en && guard < 50) begin @(negedge clk); guard++; end
        rd_hold = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (read_en !== 1'b1 || read_address !== 3'd3 || rsp_valid !== 1'b0) bad++;
        end
        chk("stall_read_held_bad_cycles", bad, 0);
        chk("stall_read_none_completed", ry_cnt - r0, 0);
        rd_hold = 1'b0;
        wait_rsp(lat);
        take_rsp(d, e);
        chk("stall_data", d, 8'h7D);
        chk("stall_writes_a", wa_cnt - w0, 1);
        chk("stall_writes_b", wb_cnt - w1, 1);
        chk("stall_reads_y", ry_cnt - r0, 1);

        // Randomized pairs with engine status stalls and write-port jitter.
        stall_en = 1'b1; rand_rdy = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a = DW'($urandom); b = DW'($urandom);
            exp_q.push_back(a | b);
            send_cmd(a, b);
            wait_rsp(lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            take_rsp(d, e);
            if (exp_q.size() > 0) chk($sformatf("rand%0d_data", i), d, exp_q.pop_front());
            chk($sformatf("rand%0d_err", i), e, 0);
        end
        stall_en = 1'b0; rand_rdy = 1'b0;

        // Timeout: result never appears.
        y_block = 1'b1;
        send_cmd(8'h5A, 8'hA5);
        py = 0; guard = 0;
        while (!rsp_valid && guard < 200) begin
            if (busy && read_address == 3'd2) py++;
            @(negedge clk);
            guard++;
        end
        chk("timeout_rsp_valid", rsp_valid, 1);
        chk("timeout_poll_y_cycles", py, TMO);
        take_rsp(d, e);
        chk("timeout_err", e, 1);
        chk("timeout_data", d, 0);
        y_block = 1'b0;
        do_reset();

        // Reset mid-operation in POLL_Y.
        y_block = 1'b1;
        send_cmd(8'h11, 8'h22);
        guard = 0;
        while (!(busy && read_address == 3'd2) && guard < 50) begin @(negedge clk); guard++; end
        chk("midrst_reached_poll_y", read_address, 2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midrst");
        @(negedge clk);
        y_block = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        send_cmd(8'h01, 8'h02);
        wait_rsp(lat);
        take_rsp(d, e);
        chk("after_reset_data", d, 8'h03);
        chk("after_reset_err", e, 0);

        chk("read_en_off_data_addr", viol, 0);
        chk("engine_fifo_overflow", ovf, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
